// File: rtl/fifo_axis_packetizer.sv
// Read-side stage for a standard-mode FIFO: 2-entry skid buffer plus fixed-length AXI-Stream packet framing.
// Define FIFO_AXIS_PKT_STATS_EN to add the PKT_COUNT / BEAT_COUNT statistics outputs.
module fifo_axis_packetizer #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  CLK,
    input  logic                  SYNC_RST,
    input  logic                  ENABLE,
    input  logic [LEN_WIDTH-1:0]  PKT_LEN,
    input  logic                  FIFO_EMPTY,
    input  logic                  FIFO_VALID,
    input  logic [DATA_WIDTH-1:0] FIFO_DOUT,
    output logic                  FIFO_RE,
    output logic                  M_TVALID,
    input  logic                  M_TREADY,
    output logic [DATA_WIDTH-1:0] M_TDATA,
    output logic                  M_TLAST,
    output logic                  BUSY
`ifdef FIFO_AXIS_PKT_STATS_EN
    ,
    output logic [31:0]           PKT_COUNT,
    output logic [31:0]           BEAT_COUNT
`endif
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] RUN       = 2'd1;
    localparam logic [1:0] STOP_PEND = 2'd2;

    localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

    logic [1:0]            state_reg;
    logic [1:0]            state_next;
    logic [1:0]            occ_reg;
    logic                  infl_reg;
    logic                  ign_valid_reg;
    logic [LEN_WIDTH-1:0]  beat_cnt_reg;
    logic [LEN_WIDTH-1:0]  len_q_reg;
    logic                  rd_ptr_reg;
    logic                  wr_ptr_reg;
    logic [DATA_WIDTH-1:0] skid_reg [2];

    logic                  pop;
    logic                  wr_en;
    logic                  tlast;
    logic                  room;
    logic                  need_more;
    logic [2:0]            committed;
    logic [2:0]            after_pop;
    logic [LEN_WIDTH:0]    remaining;
    logic [LEN_WIDTH-1:0]  pkt_len_eff;

    assign M_TVALID = (occ_reg != 2'd0) && (state_reg != IDLE);
    assign M_TDATA  = skid_reg[rd_ptr_reg];
    assign tlast    = M_TVALID && (beat_cnt_reg == len_q_reg - LEN_ONE);
    assign M_TLAST  = tlast;
    assign BUSY     = (state_reg != IDLE);

    assign pop         = M_TVALID & M_TREADY;
    // The word landing right after reset belongs to a read issued before it.
    assign wr_en       = FIFO_VALID & ~ign_valid_reg;
    assign pkt_len_eff = (PKT_LEN == '0) ? LEN_ONE : PKT_LEN;

    // Words already buffered or in flight, and what is left of the current packet.
    assign committed = {1'b0, occ_reg} + {2'b00, infl_reg};
    assign after_pop = committed - {2'b00, pop};
    assign room      = (after_pop < 3'd2);
    assign remaining = {1'b0, len_q_reg} - {1'b0, beat_cnt_reg};
    assign need_more = ({{(LEN_WIDTH-2){1'b0}}, committed} < remaining);

    assign FIFO_RE = ~FIFO_EMPTY & room &
                     ((state_reg == RUN) | ((state_reg == STOP_PEND) & need_more));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (ENABLE) state_next = RUN;
            end
            RUN: begin
                if (!ENABLE) begin
                    if (pop && tlast)
                        state_next = IDLE;
                    else if ((beat_cnt_reg == '0) && !pop)
                        state_next = IDLE;
                    else
                        state_next = STOP_PEND;
                end
            end
            STOP_PEND: begin
                // A stopping packet always runs to its TLAST beat.
                if (ENABLE)
                    state_next = RUN;
                else if (pop && tlast)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (SYNC_RST) begin
            state_reg     <= IDLE;
            occ_reg       <= 2'd0;
            infl_reg      <= 1'b0;
            ign_valid_reg <= 1'b1;
            beat_cnt_reg  <= '0;
            len_q_reg     <= LEN_ONE;
            rd_ptr_reg    <= 1'b0;
            wr_ptr_reg    <= 1'b0;
            skid_reg[0]   <= '0;
            skid_reg[1]   <= '0;
        end else begin
            state_reg     <= state_next;
            infl_reg      <= FIFO_RE;
            ign_valid_reg <= 1'b0;

            case ({wr_en, pop})
                2'b10:   occ_reg <= occ_reg + 2'd1;
                2'b01:   occ_reg <= occ_reg - 2'd1;
                default: occ_reg <= occ_reg;
            endcase

            if (wr_en) begin
                skid_reg[wr_ptr_reg] <= FIFO_DOUT;
                wr_ptr_reg           <= ~wr_ptr_reg;
            end

            if (pop) begin
                rd_ptr_reg   <= ~rd_ptr_reg;
                beat_cnt_reg <= tlast ? '0 : beat_cnt_reg + LEN_ONE;
            end

            if (((state_reg == IDLE) && (state_next == RUN)) || (pop && tlast))
                len_q_reg <= pkt_len_eff;
        end
    end

    always_ff @(posedge CLK) begin
        if (!SYNC_RST)
            assert (!(wr_en && (occ_reg == 2'd2) && !pop));
    end

`ifdef FIFO_AXIS_PKT_STATS_EN
    logic [31:0] pkt_count_reg;
    logic [31:0] beat_count_reg;

    always_ff @(posedge CLK) begin
        if (SYNC_RST) begin
            pkt_count_reg  <= 32'd0;
            beat_count_reg <= 32'd0;
        end else if (pop) begin
            beat_count_reg <= beat_count_reg + 32'd1;
            if (tlast)
                pkt_count_reg <= pkt_count_reg + 32'd1;
        end
    end

    assign PKT_COUNT  = pkt_count_reg;
    assign BEAT_COUNT = beat_count_reg;
`endif

endmodule
